// File: rtl/frogger_pkg.sv
// Shared encodings and playfield constants for the Frogger game sequencer.
package frogger_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StRunning  = 3'b001,
    StDying    = 3'b010,
    StScored   = 3'b011,
    StGameOver = 3'b100
  } state_e;

  // Lily pads sit in columns 1, 4, 7, 10 and 13 of row 0.
  localparam logic [13:0] LilyMask      = 14'h2492;
  localparam logic [5:0]  WaterRowFirst = 6'd1;
  localparam logic [5:0]  WaterRowLast  = 6'd5;
  localparam logic [5:0]  StartX        = 6'd7;
  localparam logic [5:0]  StartY        = 6'd12;
  localparam logic [2:0]  LevelMax      = 3'd7;

endpackage

// File: rtl/edge_pulse.sv
// Registered single-cycle pulse on a chosen edge of a level input.
module edge_pulse #(
  parameter bit Rise     = 1'b1,
  parameter bit ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic hist_q;
  logic pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q  <= ResetVal;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= level_i;
      pulse_q <= Rise ? (level_i & ~hist_q) : (~level_i & hist_q);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frogger_game_sequencer.sv
// Top-level Frogger game FSM: sequences play, death, scoring and game over,
// and owns score, lives and level.
module frogger_game_sequencer
  import frogger_pkg::*;
#(
  parameter int unsigned c_GAME_WIDTH    = 14,
  parameter int unsigned c_GAME_HEIGHT   = 13,
  parameter int unsigned c_LIVES         = 3,
  parameter int unsigned c_SCORE_LIMIT   = 99,
  parameter int unsigned c_PTS_PER_LEVEL = 5,
  parameter int unsigned c_DEATH_FRAMES  = 60,
  parameter int unsigned c_SCORED_FRAMES = 30
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Game_Start,
  input  logic        i_VSync,
  input  logic [5:0]  i_Frogger_X,
  input  logic [5:0]  i_Frogger_Y,
  input  logic [17:0] i_Car_X,
  input  logic [17:0] i_Car_Y,
  output logic [2:0]  o_State,
  output logic        o_Game_Active,
  output logic        o_Frog_Reset,
  output logic [6:0]  o_Score,
  output logic [1:0]  o_Lives,
  output logic [2:0]  o_Level
);

  localparam logic [6:0] ScoreLimit  = 7'(c_SCORE_LIMIT);
  localparam logic [6:0] PtsLast     = 7'(c_PTS_PER_LEVEL - 1);
  localparam logic [6:0] ScoredLast  = 7'(c_SCORED_FRAMES - 1);
  localparam logic [6:0] DeathLast   = 7'(c_DEATH_FRAMES - 1);
  localparam logic [1:0] LivesInit   = 2'(c_LIVES);

  state_e      state_q, state_d;
  logic [6:0]  score_q, score_d;
  logic [6:0]  pts_q, pts_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic [6:0]  frame_q, frame_d;
  logic        frog_reset_q, frog_reset_d;
  logic        mask_q;
  logic [5:0]  frog_x_q, frog_y_q;
  logic [17:0] car_x_q, car_y_q;

  logic start_evt;
  logic frame_tick;

  edge_pulse #(.Rise(1'b1), .ResetVal(1'b1)) u_start_edge (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .level_i (i_Game_Start),
    .pulse_o (start_evt)
  );

  edge_pulse #(.Rise(1'b0), .ResetVal(1'b1)) u_vsync_edge (
    .clk_i   (i_Clk),
    .rst_i   (i_Rst),
    .level_i (i_VSync),
    .pulse_o (frame_tick)
  );

  // Hazard decode from registered positions.
  logic [63:0] lily_cols;
  logic        in_field, pad, car_hit, drown, wall, hazards_live;

  assign lily_cols = 64'(LilyMask);
  assign in_field  = (frog_x_q < 6'(c_GAME_WIDTH)) && (frog_y_q < 6'(c_GAME_HEIGHT));
  assign pad       = in_field && (frog_y_q == 6'd0) && lily_cols[frog_x_q];
  assign drown     = in_field && (frog_y_q >= WaterRowFirst) && (frog_y_q <= WaterRowLast);
  assign wall      = in_field && (frog_y_q == 6'd0) && !pad;

  always_comb begin
    car_hit = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (frog_x_q == car_x_q[6*n +: 6] && frog_y_q == car_y_q[6*n +: 6]) car_hit = 1'b1;
    end
  end

  // The frog position lags the respawn pulse, so skip the pulse cycle and the one after.
  assign hazards_live = !frog_reset_q && !mask_q;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    pts_d        = pts_q;
    lives_d      = lives_q;
    level_d      = level_q;
    frame_d      = frame_q;
    frog_reset_d = 1'b0;
    case (state_q)
      StIdle, StGameOver: begin
        if (start_evt) begin
          state_d      = StRunning;
          frog_reset_d = 1'b1;
          score_d      = 7'd0;
          pts_d        = 7'd0;
          lives_d      = LivesInit;
          level_d      = 3'd0;
        end
      end
      StRunning: begin
        if (hazards_live) begin
          if (pad) begin
            state_d = StScored;
            frame_d = 7'd0;
            if (score_q < ScoreLimit) begin
              score_d = score_q + 7'd1;
              if (pts_q == PtsLast) begin
                pts_d = 7'd0;
                if (level_q != LevelMax) level_d = level_q + 3'd1;
              end else begin
                pts_d = pts_q + 7'd1;
              end
            end
          end else if (car_hit || drown || wall) begin
            state_d = StDying;
            frame_d = 7'd0;
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          end
        end
      end
      StScored: begin
        if (frame_tick) begin
          if (frame_q == ScoredLast) begin
            frame_d = 7'd0;
            if (score_q == ScoreLimit) begin
              state_d = StGameOver;
            end else begin
              state_d      = StRunning;
              frog_reset_d = 1'b1;
            end
          end else begin
            frame_d = frame_q + 7'd1;
          end
        end
      end
      StDying: begin
        if (frame_tick) begin
          if (frame_q == DeathLast) begin
            frame_d = 7'd0;
            if (lives_q == 2'd0) begin
              state_d = StGameOver;
            end else begin
              state_d      = StRunning;
              frog_reset_d = 1'b1;
            end
          end else begin
            frame_d = frame_q + 7'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      score_q      <= 7'd0;
      pts_q        <= 7'd0;
      lives_q      <= LivesInit;
      level_q      <= 3'd0;
      frame_q      <= 7'd0;
      frog_reset_q <= 1'b0;
      mask_q       <= 1'b0;
      frog_x_q     <= StartX;
      frog_y_q     <= StartY;
      car_x_q      <= '0;
      car_y_q      <= '0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      pts_q        <= pts_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      frame_q      <= frame_d;
      frog_reset_q <= frog_reset_d;
      mask_q       <= frog_reset_q;
      frog_x_q     <= i_Frogger_X;
      frog_y_q     <= i_Frogger_Y;
      car_x_q      <= i_Car_X;
      car_y_q      <= i_Car_Y;
    end
  end

  assign o_State       = state_q;
  assign o_Game_Active = (state_q == StRunning);
  assign o_Frog_Reset  = frog_reset_q;
  assign o_Score       = score_q;
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;

endmodule

// File: tb/tb_frogger_game_sequencer.sv
// Self-checking bench for frogger_game_sequencer: hazard vector table plus
// hand-written multi-frame sequences.
module tb_frogger_game_sequencer;

  localparam int SIdle = 0, SRun = 1, SDie = 2, SScore = 3, SOver = 4;
  localparam logic [17:0] CarXDef = {6'd12, 6'd3, 6'd0};
  localparam logic [17:0] CarYDef = {6'd7, 6'd11, 6'd10};

  logic        clk, rst, game_start, vsync;
  logic [5:0]  frog_x, frog_y;
  logic [17:0] car_x, car_y;
  logic [2:0]  state;
  logic        game_active, frog_reset;
  logic [6:0]  score;
  logic [1:0]  lives;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  frogger_game_sequencer dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Game_Start  (game_start),
    .i_VSync       (vsync),
    .i_Frogger_X   (frog_x),
    .i_Frogger_Y   (frog_y),
    .i_Car_X       (car_x),
    .i_Car_Y       (car_y),
    .o_State       (state),
    .o_Game_Active (game_active),
    .o_Frog_Reset  (frog_reset),
    .o_Score       (score),
    .o_Lives       (lives),
    .o_Level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fx;
    int          fy;
    logic [17:0] cx;
    logic [17:0] cy;
    int          st;
    int          lives;
    int          score;
  } vec_t;

  typedef struct {
    int tag;
    int st;
    int lives;
    int score;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    game_start = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_frog(input int x, input int y);
    frog_x = 6'(x);
    frog_y = 6'(y);
  endtask

  // Start press from IDLE or GAME_OVER; leaves the bench where hazards are live.
  task automatic start_game(input string tag);
    game_start = 1'b0;
    step();
    game_start = 1'b1;
    step();
    step();
    chk({tag, "_state"}, int'(state), SRun);
    chk({tag, "_pulse"}, int'(frog_reset), 1);
    chk({tag, "_lives"}, int'(lives), 3);
    chk({tag, "_score"}, int'(score), 0);
    step();
    chk({tag, "_pulse_width"}, int'(frog_reset), 0);
    game_start = 1'b0;
    step();
  endtask

  task automatic frame();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    step();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  initial begin
    exp_t e;
    int   lvl;

    vecs[0]  = '{4, 0, CarXDef, CarYDef, SScore, 3, 1};
    vecs[1]  = '{5, 0, CarXDef, CarYDef, SDie, 2, 0};
    vecs[2]  = '{3, 3, CarXDef, CarYDef, SDie, 2, 0};
    vecs[3]  = '{6, 9, {6'd12, 6'd6, 6'd0}, {6'd7, 6'd9, 6'd10}, SDie, 2, 0};
    vecs[4]  = '{7, 12, CarXDef, CarYDef, SRun, 3, 0};
    vecs[5]  = '{13, 0, CarXDef, CarYDef, SScore, 3, 1};
    vecs[6]  = '{0, 0, CarXDef, CarYDef, SDie, 2, 0};
    vecs[7]  = '{6, 5, CarXDef, CarYDef, SDie, 2, 0};
    vecs[8]  = '{6, 6, CarXDef, CarYDef, SRun, 3, 0};
    vecs[9]  = '{2, 8, {6'd2, 6'd3, 6'd0}, {6'd8, 6'd11, 6'd10}, SDie, 2, 0};
    vecs[10] = '{2, 9, {6'd12, 6'd3, 6'd2}, {6'd7, 6'd11, 6'd8}, SRun, 3, 0};
    vecs[11] = '{1, 0, {6'd12, 6'd3, 6'd1}, {6'd7, 6'd11, 6'd0}, SScore, 3, 1};
    vecs[12] = '{6, 1, CarXDef, CarYDef, SDie, 2, 0};
    vecs[13] = '{9, 4, {6'd12, 6'd3, 6'd9}, {6'd7, 6'd11, 6'd4}, SDie, 2, 0};

    rst = 1'b1;
    game_start = 1'b1;
    vsync = 1'b1;
    set_frog(7, 12);
    car_x = CarXDef;
    car_y = CarYDef;

    // Reset with Start held: no game must start.
    step();
    step();
    chk("rst_state", int'(state), SIdle);
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_pulse", int'(frog_reset), 0);
    chk("rst_active", int'(game_active), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("held_start_idle", int'(state), SIdle);
    end
    start_game("first_start");
    chk("first_active", int'(game_active), 1);

    // Start presses during RUNNING are ignored.
    game_start = 1'b1;
    step();
    step();
    step();
    chk("ignored_start_state", int'(state), SRun);
    chk("ignored_start_pulse", int'(frog_reset), 0);
    game_start = 1'b0;

    // Hazard decode table, each vector from a fresh game.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      set_frog(7, 12);
      car_x = vecs[i].cx;
      car_y = vecs[i].cy;
      start_game($sformatf("vec%0d_start", i));
      set_frog(vecs[i].fx, vecs[i].fy);
      sb.push_back('{i, vecs[i].st, vecs[i].lives, vecs[i].score});
      settle();
      e = sb.pop_front();
      chk($sformatf("vec%0d_state", e.tag), int'(state), e.st);
      chk($sformatf("vec%0d_lives", e.tag), int'(lives), e.lives);
      chk($sformatf("vec%0d_score", e.tag), int'(score), e.score);
      chk($sformatf("vec%0d_active", e.tag), int'(game_active), (e.st == SRun) ? 1 : 0);
    end
    car_x = CarXDef;
    car_y = CarYDef;

    // Score, 30-frame SCORED window, then a wall death and 60-frame DYING window.
    do_reset();
    set_frog(7, 12);
    start_game("seqb");
    set_frog(4, 0);
    settle();
    chk("seqb_scored", int'(state), SScore);
    chk("seqb_score1", int'(score), 1);
    set_frog(7, 12);
    frames(29);
    chk("seqb_scored_29", int'(state), SScore);
    sb.push_back('{100, SRun, 3, 1});
    frames(1);
    e = sb.pop_front();
    chk("seqb_scored_30", int'(state), e.st);
    chk("seqb_respawn", int'(frog_reset), 1);
    settle();
    set_frog(5, 0);
    settle();
    chk("seqb_wall_dying", int'(state), SDie);
    chk("seqb_wall_lives", int'(lives), 2);
    chk("seqb_dying_inactive", int'(game_active), 0);
    set_frog(7, 12);
    frames(59);
    chk("seqb_dying_59", int'(state), SDie);
    frames(1);
    chk("seqb_dying_60", int'(state), SRun);
    chk("seqb_dying_respawn", int'(frog_reset), 1);

    // Drain all lives in the water, then restart from GAME_OVER.
    do_reset();
    set_frog(7, 12);
    start_game("seqc");
    for (int d = 0; d < 3; d++) begin
      set_frog(3, 3);
      settle();
      chk($sformatf("seqc_die%0d_state", d), int'(state), SDie);
      chk($sformatf("seqc_die%0d_lives", d), int'(lives), 2 - d);
      set_frog(7, 12);
      if (d < 2) begin
        frames(60);
        chk($sformatf("seqc_back%0d", d), int'(state), SRun);
        settle();
      end else begin
        frames(59);
        chk("seqc_last_59", int'(state), SDie);
        frames(1);
        chk("seqc_game_over", int'(state), SOver);
        chk("seqc_over_pulse", int'(frog_reset), 0);
        chk("seqc_over_lives", int'(lives), 0);
      end
    end
    start_game("seqc_restart");
    chk("seqc_restart_level", int'(level), 0);

    // Reset during DYING after 20 frames.
    do_reset();
    set_frog(7, 12);
    start_game("seqd");
    set_frog(4, 0);
    settle();
    set_frog(7, 12);
    frames(30);
    settle();
    set_frog(3, 3);
    settle();
    chk("seqd_dying", int'(state), SDie);
    frames(20);
    rst = 1'b1;
    step();
    chk("seqd_rst_state", int'(state), SIdle);
    chk("seqd_rst_score", int'(score), 0);
    chk("seqd_rst_lives", int'(lives), 3);
    chk("seqd_rst_pulse", int'(frog_reset), 0);
    rst = 1'b0;
    set_frog(7, 12);

    // Win: frog parked on a pad rescores after each respawn mask.
    do_reset();
    start_game("seqe");
    set_frog(4, 0);
    settle();
    chk("seqe_hit1", int'(score), 1);
    for (int hit = 2; hit <= 99; hit++) begin
      frames(30);
      chk($sformatf("seqe_respawn%0d", hit), int'(frog_reset), 1);
      step();
      chk($sformatf("seqe_mask_a%0d", hit), int'(state), SRun);
      step();
      chk($sformatf("seqe_mask_b%0d", hit), int'(state), SRun);
      step();
      chk($sformatf("seqe_state%0d", hit), int'(state), SScore);
      chk($sformatf("seqe_score%0d", hit), int'(score), hit);
      lvl = (hit / 5 > 7) ? 7 : hit / 5;
      chk($sformatf("seqe_level%0d", hit), int'(level), lvl);
    end
    frames(29);
    chk("seqe_final_29", int'(state), SScore);
    frames(1);
    chk("seqe_game_over", int'(state), SOver);
    chk("seqe_over_pulse", int'(frog_reset), 0);
    for (int k = 0; k < 4; k++) step();
    chk("seqe_hold_state", int'(state), SOver);
    chk("seqe_hold_score", int'(score), 99);
    chk("seqe_hold_level", int'(level), 7);
    chk("seqe_hold_lives", int'(lives), 3);
    chk("seqe_hold_active", int'(game_active), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
